// File: rtl/ula.sv
// Registered 32-bit RV32I ALU: ten operations selected by a 4-bit code,
// result and zero flag appear one clock after the operands are applied.
module ula (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data1_in,
    input  logic [31:0] data2_in,
    input  logic [3:0]  select_ula,
    output logic [31:0] data_out,
    output logic        zero
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_AND  = 4'b1010
    } op_e;

    logic [31:0] result_d;
    logic [31:0] data_q;
    logic        zero_q;
    logic [4:0]  shamt;

    // Only the low five bits of operand B ever steer a shift.
    assign shamt = data2_in[4:0];

    always_comb begin
        // NOTE: default assigned first so every path drives result_d (no latch)
        // and unused codes fall through to zero.
        result_d = '0;
        case (op_e'(select_ula))
            OP_ADD:  result_d = data1_in + data2_in;
            OP_SUB:  result_d = data1_in - data2_in;
            OP_SLL:  result_d = data1_in << shamt;
            OP_SLT:  result_d = {31'd0, $signed(data1_in) < $signed(data2_in)};
            OP_SLTU: result_d = {31'd0, data1_in < data2_in};
            OP_SRL:  result_d = data1_in >> shamt;
            OP_SRA:  result_d = $unsigned($signed(data1_in) >>> shamt);
            OP_XOR:  result_d = data1_in ^ data2_in;
            OP_OR:   result_d = data1_in | data2_in;
            OP_AND:  result_d = data1_in & data2_in;
            default: result_d = '0;
        endcase
    end

    // zero comes from the same result_d that lands in data_q, keeping both coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all registered state.
        if (!rst_n) begin
            data_q <= '0;
            zero_q <= 1'b1;
        end else begin
            data_q <= result_d;
            zero_q <= (result_d == 32'd0);
        end
    end

    assign data_out = data_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula: directed vectors with hand-computed results,
// then randomized operations against a behavioural model, with reset pulses.
module tb_ula;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data1_in = '0;
    logic [31:0] data2_in = '0;
    logic [3:0]  select_ula = '0;
    logic [31:0] data_out;
    logic        zero;

    int checks = 0;
    int errors = 0;

    ula dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data1_in   (data1_in),
        .data2_in   (data2_in),
        .select_ula (select_ula),
        .data_out   (data_out),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = int'(b % 32);
        case (op)
            4'd1:  r = a + b;
            4'd2:  r = a - b;
            4'd3:  r = a << sh;
            4'd4:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8:  r = a ^ b;
            4'd9:  r = a | b;
            4'd10: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected output register: result of the last captured operation.
    logic [31:0] m_res = 32'd0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_res = 32'd0;
        else        m_res = model(select_ula, data1_in, data2_in);
    end

    always @(negedge clk) begin
        check("cmp_data_out", data_out, m_res);
        check("cmp_zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        select_ula = op;
        data1_in   = a;
        data2_in   = b;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk);
        #2 drive(op, a, b);
        @(posedge clk);
        #1;
        check(name, data_out, exp);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        check({name, "_model"}, model(op, a, b), exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_data_out", data_out, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        directed("add",       4'b0001, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        directed("add_wrap",  4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        directed("sub",       4'b0010, 32'h0380_0155, 32'h0005_5400, 32'h037A_AD55);
        directed("sll",       4'b0011, 32'h0380_0155, 32'h0000_0004, 32'h3800_1550);
        directed("sll_hi_b",  4'b0011, 32'h0380_0155, 32'h0000_0024, 32'h3800_1550);
        directed("slt",       4'b0100, 32'h0000_0004, 32'h0380_0155, 32'h0000_0001);
        directed("slt_neg",   4'b0100, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
        directed("sltu",      4'b0101, 32'h0380_0155, 32'h0000_0004, 32'h0000_0000);
        directed("sltu_big",  4'b0101, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001);
        directed("srl",       4'b0110, 32'h0380_0155, 32'h0000_0004, 32'h0038_0015);
        directed("sra_zero",  4'b0111, 32'h8380_0155, 32'h0000_0000, 32'h8380_0155);
        directed("xor",       4'b1000, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        directed("or",        4'b1001, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        directed("and",       4'b1010, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0000);
        directed("undef_f",   4'b1111, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0000);
        directed("undef_0",   4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000);
        directed("sra",       4'b0111, 32'h8380_0155, 32'h0000_0004, 32'hF838_0015);

        // Inputs changed twice between edges: only the values at the edge count.
        @(posedge clk);
        #2 drive(4'b1000, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        @(negedge clk);
        #1 drive(4'b0001, 32'h0000_0001, 32'h0000_0002);
        #1 check("midcycle_hold", data_out, 32'hF838_0015);
        @(posedge clk);
        #1 check("midcycle_capture", data_out, 32'h0000_0003);

        // Reset between edges clears at once; first edge after release captures.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", data_out, 32'd0);
        check("async_reset_zero", {31'd0, zero}, 32'd1);
        drive(4'b0001, 32'h0000_0002, 32'h0000_0003);
        @(posedge clk);
        #1 check("reset_held", data_out, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("release_before_edge", data_out, 32'd0);
        @(posedge clk);
        #1 check("release_first_edge", data_out, 32'h0000_0005);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            @(posedge clk);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: b = a;
                3: b = {$urandom_range(0, 7) == 0 ? 27'h7FF_FFFF : 27'd0, b[4:0]};
                default: ;
            endcase
            #2 drive(4'($urandom_range(0, 15)), a, b);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
